// File: rtl/fsm_mod_reducer.sv
// Purpose: conditional final subtraction of modular addition; S (chunks + carry) -> S mod N, streamed LSB-first.
// Latency: last beat at T -> DECIDE at T+1, chunk 0 at T+3, final chunk at T+2+DEPTH; next beats from T+3+DEPTH.
// Backpressure: ready_out only in ACCUM; beats offered while ready_out=0 are ignored; output has no backpressure.
module fsm_mod_reducer #(
  parameter int register_size = 32,
  parameter int bits_in_num   = 2048
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [register_size-1:0] chunk_in,
  input  logic                     carry_in,
  input  logic [register_size-1:0] mod_chunk_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  output logic [register_size-1:0] data_out,
  output logic                     valid_out,
  output logic                     final_out,
  output logic                     reduced_out
);

  localparam int DEPTH = bits_in_num / register_size;
  localparam int CW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW    = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);
  localparam logic [RW-1:0] RD_LAST  = RW'(DEPTH - 1);
  localparam logic [RW-1:0] RD_END   = RW'(DEPTH);

  typedef enum logic [1:0] {ACCUM, DECIDE, EMIT} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]              count;
  logic [RW-1:0]              rd_cnt;
  logic                       borrow;
  logic                       carry_r;
  logic [2*register_size-1:0] buf_mem [DEPTH];
  logic [2*register_size-1:0] rd_word;
  logic [register_size:0]     diff;
  logic                       beat_acc;
  logic                       last_beat;
  logic                       rd_act;

  assign ready_out = (state == ACCUM);
  assign beat_acc  = valid_in && ready_out;
  assign last_beat = beat_acc && (count == LAST_IDX);
  // Extra MSB of the subtraction is the borrow out of this chunk.
  assign diff      = {1'b0, chunk_in} - {1'b0, mod_chunk_in} - {{register_size{1'b0}}, borrow};
  // EMIT spends one extra cycle at rd_cnt == DEPTH so ready_out rises the cycle after final_out.
  assign rd_act    = (state == EMIT) && (rd_cnt != RD_END);
  assign rd_word   = buf_mem[rd_cnt[CW-1:0]];

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= ACCUM;
    else        state <= state_nxt;
  end

  // Next-state logic: ACCUM until the DEPTH-th beat, one DECIDE cycle, then EMIT.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (last_beat) state_nxt = DECIDE;
      DECIDE:  state_nxt = EMIT;
      EMIT:    if (rd_cnt == RD_END) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Beat counter, borrow chain, carry latch, select decision and read pointer.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count       <= '0;
      borrow      <= 1'b0;
      carry_r     <= 1'b0;
      rd_cnt      <= '0;
      reduced_out <= 1'b0;
    end else begin
      if (beat_acc) begin
        borrow <= diff[register_size];
        if (count == LAST_IDX) begin
          count   <= '0;
          carry_r <= carry_in;
        end else begin
          count <= count + 1'b1;
        end
      end
      if (state == DECIDE) begin
        // S >= N when the adder carried out or the chunk-wise subtraction did not borrow.
        reduced_out <= carry_r | ~borrow;
        borrow      <= 1'b0;
        rd_cnt      <= '0;
      end
      if (rd_act) rd_cnt <= rd_cnt + 1'b1;
    end
  end

  // Store both candidate results per chunk; the choice is only known after the last beat.
  always_ff @(posedge clk_in) begin
    if (beat_acc) buf_mem[count] <= {chunk_in, diff[register_size-1:0]};
  end

  // Registered output stage; data_out holds its value between numbers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_out <= 1'b0;
      final_out <= 1'b0;
      data_out  <= '0;
    end else begin
      valid_out <= rd_act;
      final_out <= rd_act && (rd_cnt == RD_LAST);
      if (rd_act) begin
        data_out <= reduced_out ? rd_word[register_size-1:0]
                                : rd_word[2*register_size-1:register_size];
      end
    end
  end

endmodule

// File: tb/tb_fsm_mod_reducer.sv
// Bench for fsm_mod_reducer: directed numbers plus random traffic, scoreboard-checked.
// Expected chunks, flags and arrival cycles come from a whole-number arithmetic model.
// A negedge monitor pops the scoreboard on every valid_out and also checks idle/reset behaviour.
module tb_fsm_mod_reducer;

  localparam int RS    = 8;
  localparam int BN    = 32;
  localparam int DEPTH = BN / RS;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [RS-1:0] chunk_in;
  logic          carry_in;
  logic [RS-1:0] mod_chunk_in;
  logic          valid_in;
  logic          ready_out;
  logic [RS-1:0] data_out;
  logic          valid_out;
  logic          final_out;
  logic          reduced_out;

  fsm_mod_reducer #(.register_size(RS), .bits_in_num(BN)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .chunk_in     (chunk_in),
    .carry_in     (carry_in),
    .mod_chunk_in (mod_chunk_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .final_out    (final_out),
    .reduced_out  (reduced_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [RS-1:0] dat;
    logic          red;
    logic          fin;
    int            cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   rst_q = 1'b0;

  // Model state of the driver side.
  int            busy_left = 0;
  int            bi = 0;
  logic [RS-1:0] beat_c [DEPTH];
  logic [RS-1:0] beat_m [DEPTH];

  always @(posedge clk_in) begin
    cyc   <= cyc + 1;
    rst_q <= rst_in;
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Whole-number reference: single conditional subtraction, result kept to BN bits.
  task automatic model_accept(input logic [RS-1:0] c, input logic [RS-1:0] m, input logic cy);
    logic [BN:0] s;
    logic [BN:0] n;
    logic [BN:0] r;
    logic        red;
    exp_t        e;
    beat_c[bi] = c;
    beat_m[bi] = m;
    if (bi == DEPTH - 1) begin
      s = '0;
      n = '0;
      for (int k = 0; k < DEPTH; k++) begin
        s[k*RS +: RS] = beat_c[k];
        n[k*RS +: RS] = beat_m[k];
      end
      s[BN] = cy;
      red = (s >= n);
      r = red ? (s - n) : s;
      for (int k = 0; k < DEPTH; k++) begin
        e.dat = r[k*RS +: RS];
        e.red = red;
        e.fin = (k == DEPTH - 1);
        e.cyc = cyc + 3 + k;
        sbq.push_back(e);
      end
      busy_left = DEPTH + 2;
      bi = 0;
    end else begin
      bi++;
    end
  endtask

  task automatic step(input logic v, input logic [RS-1:0] c, input logic [RS-1:0] m,
                      input logic cy, output bit acc);
    @(negedge clk_in);
    rst_in       = 1'b0;
    valid_in     = v;
    chunk_in     = c;
    mod_chunk_in = m;
    carry_in     = cy;
    check("ready_out", {31'd0, ready_out}, {31'd0, busy_left == 0});
    @(posedge clk_in);
    acc = 1'b0;
    if (busy_left > 0) busy_left--;
    else if (v) begin
      acc = 1'b1;
      model_accept(c, m, cy);
    end
  endtask

  task automatic drive_beat(input logic [RS-1:0] c, input logic [RS-1:0] m, input logic cy,
                            input bit gap, input bit garb);
    bit acc;
    acc = 1'b0;
    if (gap) step(1'b0, RS'($urandom), RS'($urandom), 1'($urandom), acc);
    acc = 1'b0;
    while (!acc) begin
      if (busy_left > 0) step(garb, RS'($urandom), RS'($urandom), 1'($urandom), acc);
      else               step(1'b1, c, m, cy, acc);
    end
  endtask

  // cy_vec[i] is carry_in presented with beat i; only the last one should matter.
  task automatic send_num(input logic [BN-1:0] s, input logic [BN-1:0] n,
                          input logic [DEPTH-1:0] cy_vec, input bit gap, input bit garb);
    for (int i = 0; i < DEPTH; i++)
      drive_beat(s[i*RS +: RS], n[i*RS +: RS], cy_vec[i], gap, garb);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in   = 1'b1;
    valid_in = 1'b0;
    @(posedge clk_in);
    busy_left = 0;
    bi = 0;
    sbq.delete();
  endtask

  // Monitor: reset values after a reset edge, scoreboard on valid_out, hold/quiet otherwise.
  always @(negedge clk_in) begin : mon
    exp_t e;
    logic [RS-1:0] hold_dat;
    if (rst_q) begin
      check("rst_ready", {31'd0, ready_out}, 32'd1);
      check("rst_valid", {31'd0, valid_out}, 32'd0);
      check("rst_final", {31'd0, final_out}, 32'd0);
      check("rst_data", {24'd0, data_out}, 32'd0);
      check("rst_reduced", {31'd0, reduced_out}, 32'd0);
      hold_dat = '0;
    end else if (valid_out) begin
      if (sbq.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("data_out", {24'd0, data_out}, {24'd0, e.dat});
        check("reduced_out", {31'd0, reduced_out}, {31'd0, e.red});
        check("final_out", {31'd0, final_out}, {31'd0, e.fin});
        check("out_cycle", cyc, e.cyc);
        hold_dat = e.dat;
      end
    end else begin
      check("data_hold", {24'd0, data_out}, {24'd0, hold_dat});
      check("final_idle", {31'd0, final_out}, 32'd0);
    end
  end

  initial begin
    bit acc;
    logic [BN-1:0] rs, rn;
    rst_in       = 1'b1;
    valid_in     = 1'b0;
    chunk_in     = '0;
    mod_chunk_in = '0;
    carry_in     = 1'b0;
    repeat (2) @(posedge clk_in);

    // S < N: pass-through.
    send_num(32'h0FFF_FFFF, 32'h1000_0001, 4'b0000, 1'b0, 1'b0);
    // S == N: all zero, reduced.
    send_num(32'h1000_0001, 32'h1000_0001, 4'b0000, 1'b0, 1'b0);
    // N < S < 2N.
    send_num(32'h2000_0005, 32'h1000_0001, 4'b0000, 1'b0, 1'b0);
    // Carry out of the adder forces subtraction, result wraps.
    send_num(32'h0000_0003, 32'hFFFF_FFFF, 4'b1000, 1'b0, 1'b0);
    // Carry on a non-last beat must be ignored.
    send_num(32'h0000_0003, 32'hFFFF_FFFF, 4'b0010, 1'b0, 1'b0);
    // Gapped input, garbage while busy, then a back-to-back number.
    send_num(32'h2000_0005, 32'h1000_0001, 4'b0000, 1'b1, 1'b1);
    send_num(32'h0FFF_FFFF, 32'h1000_0001, 4'b0000, 1'b0, 1'b1);

    // Partial number discarded by reset.
    repeat (DEPTH + 4) step(1'b0, '0, '0, 1'b0, acc);
    drive_beat(8'hAA, 8'h11, 1'b0, 1'b0, 1'b0);
    drive_beat(8'hBB, 8'h22, 1'b0, 1'b0, 1'b0);
    do_reset();
    send_num(32'h0000_0005, 32'h0000_0001, 4'b0000, 1'b0, 1'b0);

    // Random traffic: half constrained to S < 2N, half unconstrained.
    for (int t = 0; t < 30; t++) begin
      rn = $urandom;
      rs = $urandom;
      if (t[0]) rs = (rn >> 1) + BN'($urandom_range(0, 255));
      send_num(rs, rn, DEPTH'($urandom), 1'($urandom), 1'($urandom));
    end

    // Drain with a bounded wait.
    for (int w = 0; w < 40 && sbq.size() != 0; w++) @(negedge clk_in);
    check("scoreboard_drained", sbq.size(), 32'd0);
    valid_in = 1'b0;
    repeat (4) @(negedge clk_in);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fsm_mod_reducer.md
Name: fsm_mod_reducer

Overview:
- Downstream stage of the chunked streaming adder. Consumes the LSB-first sum stream (chunks plus final carry) and an aligned modulus stream.
- Produces (S mod N) for S < 2N, i.e. the conditional final subtraction of modular addition, streamed back out LSB-first in register_size chunks.
- Sits between the adder and the next Paillier/election accumulation stage.

Parameters:
- register_size, 32, chunk width in bits.
- bits_in_num, 2048, operand width; DEPTH = bits_in_num/register_size chunks per number.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- chunk_in  input  register_size  sum chunk, LSB chunk first
- carry_in  input  1  adder carry-out; sampled only on the last accepted beat
- mod_chunk_in  input  register_size  modulus chunk with the same index as chunk_in, sampled with it
- valid_in  input  1  chunk_in/mod_chunk_in valid this cycle
- ready_out  output  1  high while the block accepts input beats (ACCUM state)
- data_out  output  register_size  reduced result chunk, LSB first
- valid_out  output  1  data_out valid
- final_out  output  1  high with the last (DEPTH-1) output chunk
- reduced_out  output  1  1 = subtraction applied; valid from the first valid_out until the next decision

Behaviour:
- Reset: state ACCUM, count 0, borrow 0, ready_out 1, valid_out 0, final_out 0, data_out 0, reduced_out 0. Reset mid-operation discards partial or stored data. The next accepted beat is chunk 0.
- Beat acceptance: a beat is accepted only when valid_in && ready_out. valid_in while ready_out=0 is ignored, with no error and no state change. Gaps between beats are allowed.

ACCUM, per accepted beat i (count = i):
- diff = chunk_in - mod_chunk_in - borrow, computed as a (register_size+1)-bit subtraction.
- Write {chunk_in, diff[register_size-1:0]} into an internal buffer at index i. The buffer is DEPTH entries of 2*register_size bits.
- borrow <= diff[register_size].
- When count == DEPTH-1: latch carry_in into carry_r, set count to 0, go to DECIDE, and drop ready_out next cycle.
- Otherwise count increments.

DECIDE (1 cycle):
- sel = carry_r | ~borrow, meaning S >= N with the full value S = {carry_r, chunks}.
- reduced_out <= sel.
- Go to EMIT with read index 0.

EMIT:
- One buffer read per cycle at indices 0..DEPTH-1 consecutively. The output is registered one cycle after the read.
- data_out = sel ? stored diff : stored sum.
- valid_out is high for exactly DEPTH consecutive cycles, with no gaps and no output backpressure.
- final_out is high only with chunk DEPTH-1.
- After the last read, return to ACCUM. ready_out goes high in the cycle after final_out.

Arithmetic rules:
- Upstream guarantees S < 2N, so a single subtraction is sufficient.
- When carry_r = 1, the diff is correct modulo 2^bits_in_num.
- S == N yields all-zero chunks with reduced_out = 1.

Latency:
- If the last input beat is accepted at cycle T: DECIDE occurs at T+1, output chunk 0 at T+3, and chunk DEPTH-1 with final_out at T+2+DEPTH.
- The next number's beats are accepted from T+3+DEPTH.

Other rules:
- data_out holds its last value when valid_out = 0. Contents are don't-care, but must be stable.
- carry_in is ignored on all non-last beats.
- Counting is by accepted beats only; no separate last-beat input exists.

Test Plan (register_size=8, bits_in_num=32, DEPTH=4; chunks listed LSB first):
- S=0x0FFFFFFF, carry 0, N=0x10000001 (inputs FF,FF,FF,0F / 01,00,00,10) -> outputs FF,FF,FF,0F; reduced_out 0; final_out on 4th chunk; first valid_out exactly 3 cycles after last input.
- S=N=0x10000001, carry 0 -> outputs 00,00,00,00; reduced_out 1.
- S=0x20000005, N=0x10000001 -> outputs 04,00,00,10; reduced_out 1.
- Chunks 03,00,00,00 with carry_in 1 on last beat, N=0xFFFFFFFF -> outputs 04,00,00,00; reduced_out 1. Also check that carry_in=1 on beat 1 only (0 on last beat) gives outputs 03,00,00,00 with reduced_out 0.
- valid_in toggling every other cycle during ACCUM, and valid_in held high through DECIDE/EMIT with garbage data -> result matches gap-free case; garbage beats are not counted; two numbers back-to-back are both correct.
- Two beats accepted, then rst_in pulsed for 1 cycle, then full number 05,00,00,00 / N 01,00,00,00 -> outputs 04,00,00,00, reduced_out 1; no valid_out emitted for the pre-reset partial number.
